alu_acc_pipe: RTL and testbench

Parametrised successor to the team's 8-bit accumulator ALU. It keeps the same 16-opcode set and adds a valid/ready handshake on input and output, a multi-cycle restoring divider, and status flags. ALU_out shows the new accumulator value in the cycle the result is presented, with no extra lag cycle. It sits between the instruction sequencer and the result bus.

---
 rtl/alu_acc_pipe.sv | 190 +++++++++++++++++++
 tb/tb_alu_acc_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_acc_pipe.sv
// Accumulator ALU with valid/ready handshakes on both sides.
// DIV runs a restoring divider, one quotient bit per cycle.
module alu_acc_pipe #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SEL_W-1:0] ALU_Sel,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_out,
    output logic             carry,
    output logic             zero,
    output logic             div_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [SEL_W-1:0] OP_ADD  = 4'h0;
    localparam logic [SEL_W-1:0] OP_SUB  = 4'h1;
    localparam logic [SEL_W-1:0] OP_MUL  = 4'h2;
    localparam logic [SEL_W-1:0] OP_DIV  = 4'h3;
    localparam logic [SEL_W-1:0] OP_ADDA = 4'h4;
    localparam logic [SEL_W-1:0] OP_MULA = 4'h5;
    localparam logic [SEL_W-1:0] OP_MAC  = 4'h6;
    localparam logic [SEL_W-1:0] OP_ROL  = 4'h7;
    localparam logic [SEL_W-1:0] OP_ROR  = 4'h8;
    localparam logic [SEL_W-1:0] OP_AND  = 4'h9;
    localparam logic [SEL_W-1:0] OP_OR   = 4'hA;
    localparam logic [SEL_W-1:0] OP_XOR  = 4'hB;
    localparam logic [SEL_W-1:0] OP_NAND = 4'hC;
    localparam logic [SEL_W-1:0] OP_EQ   = 4'hD;
    localparam logic [SEL_W-1:0] OP_GT   = 4'hE;
    localparam logic [SEL_W-1:0] OP_LT   = 4'hF;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [CW-1:0]      r_cnt;
    logic               r_vld;
    logic               r_c;
    logic               r_z;
    logic               r_e;

    logic               w_accept;
    logic               w_div_go;
    logic               w_vld_nxt;
    logic               w_err;
    logic [WIDTH-1:0]   w_acc_op;
    logic [WIDTH-1:0]   w_ma;
    logic [WIDTH-1:0]   w_mb;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_sa;
    logic [WIDTH-1:0]   w_sb;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic [WIDTH:0]     w_rs;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;

    assign in_ready  = (r_state != S_DIV) && (!r_vld || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_div_go  = w_accept && (ALU_Sel == OP_DIV) && (B != '0);
    assign w_vld_nxt = (w_accept && !w_div_go) || (r_vld && !out_ready);
    assign w_err     = (ALU_Sel == OP_DIV);
    // Clear lands before the operation so a same-edge op sees Acc=0.
    assign w_acc_op  = (acc_clr && r_state == S_IDLE) ? '0 : r_acc;

    assign w_ma   = (ALU_Sel == OP_MULA) ? w_acc_op : A;
    assign w_mb   = (ALU_Sel == OP_MULA) ? A : B;
    assign w_prod = {{WIDTH{1'b0}}, w_ma} * {{WIDTH{1'b0}}, w_mb};
    assign w_ovf  = |w_prod[2*WIDTH-1:WIDTH];
    assign w_sa   = (ALU_Sel == OP_ADD) ? A : w_acc_op;
    assign w_sb   = (ALU_Sel == OP_ADD)  ? B :
                    (ALU_Sel == OP_ADDA) ? A : w_prod[WIDTH-1:0];
    assign w_sum  = {1'b0, w_sa} + {1'b0, w_sb};

    assign w_rs      = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_rs >= {1'b0, r_dvs});
    assign w_rem_nxt = w_ge ? (w_rs[WIDTH-1:0] - r_dvs) : w_rs[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        unique case (ALU_Sel)
            OP_ADD, OP_ADDA: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res = A - B;
                w_c   = (A < B);
            end
            OP_MUL, OP_MULA: begin
                w_res = w_prod[WIDTH-1:0];
                w_c   = w_ovf;
            end
            OP_DIV:  w_res = '1;
            OP_MAC: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_ovf | w_sum[WIDTH];
            end
            OP_ROL:  w_res = {A[WIDTH-2:0], A[WIDTH-1]};
            OP_ROR:  w_res = {A[0], A[WIDTH-1:1]};
            OP_AND:  w_res = A & B;
            OP_OR:   w_res = A | B;
            OP_XOR:  w_res = A ^ B;
            OP_NAND: w_res = ~(A & B);
            OP_EQ:   w_res = {WIDTH{A == B}};
            OP_GT:   w_res = {WIDTH{A > B}};
            OP_LT:   w_res = {WIDTH{A < B}};
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_out   <= '0;
            r_dvs   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_vld   <= 1'b0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_e     <= 1'b0;
        end else if (r_state == S_DIV) begin
            if (r_cnt == CNT_LAST) begin
                r_acc   <= r_quo;
                r_out   <= r_quo;
                r_c     <= 1'b0;
                r_z     <= (r_quo == '0);
                r_e     <= 1'b0;
                r_vld   <= 1'b1;
                r_state <= out_ready ? S_IDLE : S_HOLD;
            end else begin
                r_quo <= w_quo_nxt;
                r_rem <= w_rem_nxt;
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_acc <= w_acc_op;
            if (r_vld && out_ready) r_vld <= 1'b0;
            if (w_div_go) begin
                r_dvs   <= B;
                r_quo   <= A;
                r_rem   <= '0;
                r_cnt   <= '0;
                r_state <= S_DIV;
            end else begin
                r_state <= (w_vld_nxt && !out_ready) ? S_HOLD : S_IDLE;
                if (w_accept) begin
                    r_out <= w_res;
                    r_c   <= w_c;
                    r_z   <= (w_res == '0);
                    r_e   <= w_err;
                    r_vld <= 1'b1;
                    if (!w_err) r_acc <= w_res;
                end
            end
        end
    end

    assign out_valid = r_vld;
    assign ALU_out   = r_out;
    assign carry     = r_c;
    assign zero      = r_z;
    assign div_err   = r_e;

endmodule

// File: tb/tb_alu_acc_pipe.sv
// Bench for alu_acc_pipe: transaction model checked every cycle
// plus directed vectors with hand-computed results.
module tb_alu_acc_pipe;

    localparam int W = 8;
    localparam int M = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   ALU_Sel = '0;
    logic         acc_clr = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] ALU_out;
    logic         carry;
    logic         zero;
    logic         div_err;

    int n_chk = 0;
    int n_pass = 0;

    alu_acc_pipe #(.WIDTH(W), .SEL_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALU_Sel(ALU_Sel), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALU_out(ALU_out), .carry(carry), .zero(zero),
        .div_err(div_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    endtask

    // Reference behaviour of one single-cycle opcode, plain arithmetic.
    function automatic void ref_op(input int op, input int a, input int b,
                                   input int ac, output int res,
                                   output bit c, output bit e);
        int p;
        int s;
        res = 0; c = 0; e = 0;
        case (op)
            0: begin s = a + b; res = s & M; c = (s > M); end
            1: begin res = (a - b) & M; c = (a < b); end
            2: begin p = a * b; res = p & M; c = (p > M); end
            3: begin res = M; e = 1; end
            4: begin s = ac + a; res = s & M; c = (s > M); end
            5: begin p = ac * a; res = p & M; c = (p > M); end
            6: begin
                p = a * b; s = ac + (p & M);
                res = s & M; c = (p > M) || (s > M);
            end
            7: res = ((a << 1) | (a >> (W - 1))) & M;
            8: res = ((a >> 1) | ((a & 1) << (W - 1))) & M;
            9: res = a & b;
            10: res = a | b;
            11: res = a ^ b;
            12: res = (~(a & b)) & M;
            13: res = (a == b) ? M : 0;
            14: res = (a > b) ? M : 0;
            default: res = (a < b) ? M : 0;
        endcase
    endfunction

    int m_acc, m_out, m_q, m_busy;
    bit m_vld, m_c, m_z, m_e, m_hold, started;

    always @(posedge clk) begin
        int r;
        bit c, e, acc_ok;
        started = 1;
        if (reset) begin
            m_acc = 0; m_out = 0; m_vld = 0; m_c = 0; m_z = 0; m_e = 0;
            m_busy = 0; m_hold = 0;
        end else if (m_busy > 0) begin
            m_busy--;
            m_hold = 0;
            if (m_busy == 0) begin
                m_acc = m_q; m_out = m_q; m_c = 0; m_e = 0;
                m_z = (m_q == 0); m_vld = 1; m_hold = !out_ready;
            end
        end else begin
            acc_ok = in_valid && (!m_vld || out_ready);
            if (acc_clr && !m_hold) m_acc = 0;
            if (m_vld && out_ready) m_vld = 0;
            if (acc_ok) begin
                if (ALU_Sel == 3 && B != 0) begin
                    m_busy = W + 1;
                    m_q = int'(A) / int'(B);
                end else begin
                    ref_op(int'(ALU_Sel), int'(A), int'(B), m_acc, r, c, e);
                    m_out = r; m_c = c; m_e = e; m_z = (r == 0); m_vld = 1;
                    if (!e) m_acc = r;
                end
            end
            m_hold = (m_busy == 0) && m_vld && !out_ready;
        end
    end

    always @(negedge clk) begin
        logic [12:0] got, exp;
        bit m_inr;
        if (started) begin
            m_inr = (m_busy == 0) && (!m_vld || out_ready);
            got = {out_valid, in_ready, ALU_out, carry, zero, div_err};
            exp = {m_vld, m_inr, W'(m_out), m_c, m_z, m_e};
            chk("model", 32'(got), 32'(exp));
        end
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit clr);
        ALU_Sel = op; A = a; B = b; acc_clr = clr; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; acc_clr = 1'b0;
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         c;
    } vec_t;

    vec_t vt[$] = '{
        '{4'h7, 8'h81, 8'h00, 8'h03, 1'b0},
        '{4'h8, 8'h81, 8'h00, 8'hC0, 1'b0},
        '{4'hA, 8'h0F, 8'hF0, 8'hFF, 1'b0},
        '{4'hC, 8'hFF, 8'hFF, 8'h00, 1'b0},
        '{4'hD, 8'h05, 8'h05, 8'hFF, 1'b0},
        '{4'hE, 8'h03, 8'h09, 8'h00, 1'b0},
        '{4'hF, 8'h03, 8'h09, 8'hFF, 1'b0},
        '{4'h2, 8'h10, 8'h10, 8'h00, 1'b1},
        '{4'h1, 8'h03, 8'h09, 8'hFA, 1'b1}
    };

    initial begin
        int lat;
        int bad;
        in_valid = 1'b1; A = 8'd1; B = 8'd1; ALU_Sel = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_out", 32'(ALU_out), 0);
        chk("rst_ready", 32'(in_ready), 1);

        issue(4'h0, 8'hF0, 8'h20, 0);
        chk("add_valid", 32'(out_valid), 1);
        chk("add_out", 32'(ALU_out), 32'h10);
        chk("add_carry", 32'(carry), 1);
        chk("add_zero", 32'(zero), 0);
        issue(4'h1, 8'd5, 8'd5, 0);
        chk("sub_out", 32'(ALU_out), 0);
        chk("sub_zero", 32'(zero), 1);
        chk("sub_carry", 32'(carry), 0);

        issue(4'h4, 8'd3, 8'd0, 1);
        chk("adda_clr", 32'(ALU_out), 3);
        issue(4'h6, 8'd4, 8'd5, 0);
        chk("mac_out", 32'(ALU_out), 32'h17);
        issue(4'h5, 8'd16, 8'd0, 0);
        chk("mula_out", 32'(ALU_out), 32'h70);
        chk("mula_carry", 32'(carry), 1);

        issue(4'h3, 8'd200, 8'd7, 0);
        lat = 0; bad = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
            if (in_ready) bad++;
        end
        chk("div_latency", 32'(lat), 9);
        chk("div_busy_ready", 32'(bad), 0);
        chk("div_out", 32'(ALU_out), 28);
        issue(4'h3, 8'd9, 8'd0, 0);
        chk("div0_out", 32'(ALU_out), 32'hFF);
        chk("div0_err", 32'(div_err), 1);
        chk("div0_carry", 32'(carry), 0);
        issue(4'h4, 8'd0, 8'd0, 0);
        chk("div0_acc_kept", 32'(ALU_out), 28);

        foreach (vt[k]) begin
            issue(vt[k].op, vt[k].a, vt[k].b, 0);
            chk($sformatf("vec%0d_out", k), 32'(ALU_out), 32'(vt[k].res));
            chk($sformatf("vec%0d_carry", k), 32'(carry), 32'(vt[k].c));
        end

        issue(4'h9, 8'hCC, 8'hAA, 0);
        out_ready = 1'b0;
        chk("and_out", 32'(ALU_out), 32'h88);
        repeat (5) begin
            @(posedge clk); #1;
            chk("hold_out", 32'(ALU_out), 32'h88);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", 32'(in_ready), 1);
        issue(4'hB, 8'hCC, 8'hAA, 0);
        chk("xor_valid", 32'(out_valid), 1);
        chk("xor_out", 32'(ALU_out), 32'h66);

        issue(4'h3, 8'd100, 8'd3, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bad = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        chk("abort_no_valid", 32'(bad), 0);
        issue(4'h4, 8'd5, 8'd0, 0);
        chk("abort_acc_zero", 32'(ALU_out), 5);
        issue(4'h0, 8'd1, 8'd1, 0);
        chk("post_abort_add", 32'(ALU_out), 2);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
